shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter that shares one W-bit pipeline holding register among the four cores. Each core raises a request with its operand. The arbiter grants one core, captures its operand and core id, and holds them for a fixed LAT-cycle occupancy. It then presents the result to the downstream stage with a valid/ready handshake. It sits between the per-core pipeline register banks and the shared execution stage.

## Interface
- W, 64, operand width in bits
- LAT, 4, occupancy in cycles from capture to out_valid; legal range 1..15

- clk  input  1  clock; all state updates on the falling edge of clk
- rst  input  1  synchronous, active-high reset, sampled on the falling edge of clk
- req  input  4  per-core request; bit i belongs to core i
- req_data  input  4*W  operands; core i drives bits [i*W+W-1 : i*W]
- gnt  output  4  one-hot grant, high for exactly one cycle
- out_data  output  W  captured operand
- out_id  output  2  index of the core that owns out_data
- out_valid  output  1  out_data/out_id are ready for the downstream stage
- out_ready  input  1  downstream accepts the data
- busy  output  1  high whenever the state is not IDLE
- lock  input  4  present only with SHARED_ARB_LOCK_EN; per-core priority hold

## Operation
- States: IDLE, BUSY, VALID.
- ptr (2 bits) is the highest-priority core. The search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
- Capture event, taken on an edge with req≠0 in IDLE, or in VALID with out_ready=1:
  - winner = first set req bit in search order.
  - out_data ← winner's slice of req_data; out_id ← winner.
  - gnt ← onehot(winner).
  - ptr ← winner+1 mod 4.
  - cnt ← LAT−1; state → BUSY.
- gnt is cleared on the edge after it is set. A core holds req and its data until it sees its gnt bit. A req still high after gnt is treated as a new request.
- BUSY: on each edge, if cnt==0 go to VALID with out_valid←1; otherwise decrement cnt. Requests are ignored in BUSY.
- VALID: out_data, out_id and out_valid stay stable until out_ready=1 at an edge. On that edge:
  - if req≠0, a capture event occurs on the same edge (back-to-back, no bubble);
  - otherwise go to IDLE with out_valid←0.
- Reset values: state=IDLE, ptr=0, cnt=0, gnt=0, out_valid=0, out_data=0, out_id=0, busy=0.
- Reset mid-operation wins over every other event. An in-flight transaction is discarded and no out_valid is produced for it.
- out_ready while not in VALID is ignored.
- With req=0 in IDLE, nothing changes.

## Timing
- Capture-to-valid latency: out_valid rises exactly LAT falling edges after the capture edge.
- gnt is visible for the half-period-aligned cycle that follows the capture edge, and for one cycle only.
- Minimum throughput: one transaction per LAT+1 cycles (LAT in BUSY, plus one in VALID with out_ready=1 and a new capture).
- Maximum wait for a requester that holds req: 3 transactions.
- No combinational path from req or out_ready to any output.

## Configuration
- SHARED_ARB_LOCK_EN defined:
  - the lock port exists;
  - if lock[winner]=1 at the capture edge, ptr ← winner instead of winner+1, so the same core keeps top priority on the next capture;
  - lock of non-winners is ignored.
- SHARED_ARB_LOCK_EN undefined:
  - no lock port;
  - ptr always advances to winner+1.

## Test plan
- Single request: reset, then req=0100 with slice 2 = 64'hA5A5_0000_1234_5678, LAT=4, out_ready=1 → gnt=0100 for one cycle; out_valid 4 edges after capture; out_id=2; out_data=64'hA5A5_0000_1234_5678; busy high throughout.
- Fairness: req=1111 held, out_ready=1 → grant order cores 0,1,2,3,0,1; captures exactly 5 cycles apart (LAT+1); no idle cycle between transactions.
- Backpressure: in VALID, out_ready=0 for 10 cycles with req=1111 → out_valid, out_data and out_id unchanged; gnt stays 0; raising out_ready gives a capture on that same edge.
- Reset mid-flight: assert rst in BUSY with cnt=2 → after the next edge all outputs are 0, state is IDLE, ptr=0; next req=1000 is granted core 3 with no stale out_valid.
- Lock (macro on): req=1010, lock=0010 → grants 1,1,1; clear lock → next grant is core 3, then core 1.
- LAT=1 boundary: req=0001 → out_valid one edge after capture; cnt never underflows.

Source files
------------

// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if
//   Bundles the request side (per-core req/operands) and the downstream
//   valid/ready side of shared_reg_arbiter into one interface.
//
//   Signals:
//     req[3:0]        per-core request, bit i belongs to core i
//     req_data[4*W]   operands, core i drives [i*W +: W]
//     gnt[3:0]        one-hot grant, high for one cycle after capture
//     out_data[W]     captured operand
//     out_id[1:0]     core that owns out_data
//     out_valid       out_data/out_id valid for the downstream stage
//     out_ready       downstream accepts the data
//     busy            arbiter is not idle
//     lock[3:0]       per-core priority hold (only with SHARED_ARB_LOCK_EN)
//
//   Modports:
//     master  cores + downstream stage (drive req/req_data/out_ready/lock)
//     slave   the arbiter itself
//
//   Optional feature macro: SHARED_ARB_LOCK_EN
interface shared_reg_arbiter_if #(
    parameter int unsigned W = 64
);
    logic [3:0]     req;
    logic [4*W-1:0] req_data;
    logic [3:0]     gnt;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
`ifdef SHARED_ARB_LOCK_EN
    logic [3:0]     lock;

    modport master (
        output req, req_data, out_ready, lock,
        input  gnt, out_data, out_id, out_valid, busy
    );

    modport slave (
        input  req, req_data, out_ready, lock,
        output gnt, out_data, out_id, out_valid, busy
    );
`else
    modport master (
        output req, req_data, out_ready,
        input  gnt, out_data, out_id, out_valid, busy
    );

    modport slave (
        input  req, req_data, out_ready,
        output gnt, out_data, out_id, out_valid, busy
    );
`endif
endinterface

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin arbiter sharing one W-bit holding register among four cores.
//   A granted core's operand and id are captured, held for LAT cycles, then
//   offered downstream with a valid/ready handshake. All state changes on the
//   falling edge of clk.
//
//   Parameters:
//     W    operand width (default 64)
//     LAT  occupancy from capture to out_valid, legal range 1..15 (default 4)
//
//   Ports:
//     clk   clock, state updates on the falling edge
//     rst   synchronous active-high reset, sampled on the falling edge
//     bus   shared_reg_arbiter_if.slave: req, req_data, out_ready, [lock] in;
//           gnt, out_data, out_id, out_valid, busy out (all registered)
//
//   Optional feature macro: SHARED_ARB_LOCK_EN
//     When defined, lock[winner] at the capture edge keeps the winner at top
//     priority for the next capture instead of advancing the pointer.
module shared_reg_arbiter #(
    parameter int unsigned W   = 64,
    parameter int unsigned LAT = 4
) (
    input  logic                clk,
    input  logic                rst,
    shared_reg_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        VALID
    } state_t;

    state_t       state;
    logic [1:0]   ptr;
    logic [3:0]   cnt;
    logic [3:0]   gnt_q;
    logic [W-1:0] data_q;
    logic [1:0]   id_q;
    logic         valid_q;
    logic         busy_q;

    logic [1:0]   winner;
    logic [1:0]   cand;
    logic         found;
    logic [1:0]   next_ptr;
    logic         capture;

    // First set request bit in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    always_comb begin
        winner = ptr;
        cand   = ptr;
        found  = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr + i[1:0];
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Capture from IDLE, or back-to-back on the handshake edge in VALID.
    always_comb begin
        capture = 1'b0;
        if (|bus.req) begin
            if (state == IDLE) begin
                capture = 1'b1;
            end else if (state == VALID && bus.out_ready) begin
                capture = 1'b1;
            end
        end
    end

`ifdef SHARED_ARB_LOCK_EN
    always_comb begin
        next_ptr = winner + 2'd1;
        if (bus.lock[winner]) begin
            next_ptr = winner;
        end
    end
`else
    always_comb begin
        next_ptr = winner + 2'd1;
    end
`endif

    always_ff @(negedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            gnt_q <= '0;
            if (capture) begin
                data_q  <= bus.req_data[winner*W +: W];
                id_q    <= winner;
                gnt_q   <= 4'b0001 << winner;
                ptr     <= next_ptr;
                cnt     <= 4'(LAT - 1);
                state   <= BUSY;
                busy_q  <= 1'b1;
                valid_q <= 1'b0;
            end else begin
                case (state)
                    BUSY: begin
                        if (cnt == 4'd0) begin
                            state   <= VALID;
                            valid_q <= 1'b1;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    VALID: begin
                        // Handshake with no pending request: release.
                        if (bus.out_ready) begin
                            state   <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.out_data  = data_q;
    assign bus.out_id    = id_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter
//   Drives shared_reg_arbiter (LAT=4) with directed and random traffic and
//   checks it against a transaction-level reference model plus a scoreboard
//   of expected outputs. A second instance with LAT=1 covers the minimum
//   occupancy. The DUT acts on falling edges; the bench samples on rising
//   edges and drives 1 ns after them.
module tb_shared_reg_arbiter;

    localparam int unsigned W   = 64;
    localparam int unsigned LAT = 4;

    logic clk = 1'b1;
    logic rst;
    logic rst1;

    always #5 clk = ~clk;

    shared_reg_arbiter_if #(.W(W)) bus ();
    shared_reg_arbiter_if #(.W(W)) bus1 ();

    shared_reg_arbiter #(.W(W), .LAT(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    shared_reg_arbiter #(.W(W), .LAT(1)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] data;
        int           vedge;
    } txn_t;

    txn_t         exp_q[$];
    txn_t         cur;
    int           edge_n    = 0;
    bit           inflight  = 0;
    int           cap_edge  = 0;
    int           ptr_m     = 0;
    logic [1:0]   last_id   = '0;
    logic [W-1:0] last_data = '0;
    bit           prev_valid = 0;
    logic [3:0]   glog[$];
    int           gedge[$];

    always @(posedge clk) begin
        logic [3:0] r;
        logic [3:0] eg;
        bit         cap;
        bit         hit;
        int         win;
        r   = bus.req;
        eg  = '0;
        cap = 0;
        hit = 0;
        win = 0;
        edge_n++;
        if (rst) begin
            inflight  = 0;
            ptr_m     = 0;
            last_id   = '0;
            last_data = '0;
            exp_q.delete();
        end else begin
            if (!inflight) begin
                cap = (r != 4'd0);
            end else if ((edge_n - cap_edge > int'(LAT)) && bus.out_ready) begin
                if (r != 4'd0) cap = 1;
                else inflight = 0;
            end
            if (cap) begin
                for (int i = 0; i < 4; i++) begin
                    if (!hit && r[(ptr_m + i) % 4]) begin
                        hit = 1;
                        win = (ptr_m + i) % 4;
                    end
                end
                ptr_m = (win + 1) % 4;
`ifdef SHARED_ARB_LOCK_EN
                if (bus.lock[win]) ptr_m = win;
`endif
                eg[win]   = 1'b1;
                last_id   = 2'(win);
                last_data = bus.req_data[win*W +: W];
                exp_q.push_back('{id: 2'(win), data: last_data, vedge: edge_n + int'(LAT)});
                cap_edge  = edge_n;
                inflight  = 1;
            end
        end
        check("gnt", W'(bus.gnt), W'(eg));
        check("busy", W'(bus.busy), W'(inflight));
        check("out_valid", W'(bus.out_valid), W'(inflight && (edge_n - cap_edge >= int'(LAT))));
        check("out_id", W'(bus.out_id), W'(last_id));
        check("out_data", bus.out_data, last_data);
        if (bus.gnt != 4'd0) begin
            glog.push_back(bus.gnt);
            gedge.push_back(edge_n);
        end
        if (bus.out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: out_valid rose with no expected transaction at %0t", $time);
            end else begin
                cur = exp_q.pop_front();
                check("sb_id", W'(bus.out_id), W'(cur.id));
                check("sb_data", bus.out_data, cur.data);
                check("sb_latency", W'(edge_n), W'(cur.vedge));
            end
        end
        prev_valid = bus.out_valid;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Granted cores get fresh operands; with hold=0 they also drop req and
    // idle cores randomly raise new requests.
    task automatic cores_update(input bit hold);
        for (int i = 0; i < 4; i++) begin
            if (bus.gnt[i]) begin
                bus.req_data[i*W +: W] = {$urandom, $urandom};
                if (!hold) bus.req[i] = 1'b0;
            end else if (!hold && !bus.req[i] && ($urandom % 3 == 0)) begin
                bus.req_data[i*W +: W] = {$urandom, $urandom};
                bus.req[i] = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input int budget, input bit hold);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            step();
            cores_update(hold);
            if (bus.gnt != 4'd0) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_gnt: no grant within %0d cycles", budget);
        end
    endtask

    initial begin
        rst            = 1'b1;
        rst1           = 1'b1;
        bus.req        = '0;
        bus.req_data   = '0;
        bus.out_ready  = 1'b0;
        bus1.req       = '0;
        bus1.req_data  = '0;
        bus1.out_ready = 1'b0;
`ifdef SHARED_ARB_LOCK_EN
        bus.lock       = '0;
        bus1.lock      = '0;
`endif
        step();
        step();
        rst = 1'b0;

        // Single request from core 2.
        bus.req_data[2*W +: W] = 64'hA5A5_0000_1234_5678;
        bus.req       = 4'b0100;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            cores_update(0);
            bus.req = bus.req & 4'b0100;
        end

        // Fairness: all cores request continuously.
        do_reset();
        for (int i = 0; i < 4; i++) bus.req_data[i*W +: W] = {$urandom, $urandom};
        bus.req = 4'b1111;
        glog.delete();
        gedge.delete();
        for (int k = 0; k < 30; k++) begin
            step();
            cores_update(1);
        end
        if (glog.size() < 6) begin
            checks++;
            errors++;
            $display("FAIL fair_count: got %0d grants required at least 6", glog.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                check("fair_order", W'(glog[k]), W'(4'b0001 << (k % 4)));
                if (k > 0) check("fair_spacing", W'(gedge[k] - gedge[k-1]), W'(LAT + 1));
            end
        end

        // Backpressure in VALID with all requests pending.
        begin
            bit got;
            got = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                step();
                cores_update(1);
                if (bus.out_valid) got = 1;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL bp_wait: out_valid not seen within 20 cycles");
            end
        end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            cores_update(1);
        end
        glog.delete();
        bus.out_ready = 1'b1;
        step();
        check("bp_release_gnt", W'(glog.size()), W'(1));
        for (int k = 0; k < 8; k++) begin
            step();
            cores_update(1);
        end

        // Reset while BUSY with cnt=2.
        wait_gnt(20, 1);
        step();
        rst = 1'b1;
        step();
        rst     = 1'b0;
        bus.req = 4'b1000;
        glog.delete();
        for (int k = 0; k < 12; k++) begin
            step();
            cores_update(0);
        end
        if (glog.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rst_regrant: no grant after reset");
        end else begin
            check("rst_regrant", W'(glog[0]), W'(4'b1000));
        end

`ifdef SHARED_ARB_LOCK_EN
        // Lock keeps core 1 at top priority.
        do_reset();
        bus.req  = 4'b1010;
        bus.lock = 4'b0010;
        glog.delete();
        wait_gnt(20, 1);
        wait_gnt(20, 1);
        bus.lock = 4'b0000;
        wait_gnt(20, 1);
        wait_gnt(20, 1);
        wait_gnt(20, 1);
        if (glog.size() >= 5) begin
            check("lock_g0", W'(glog[0]), W'(4'b0010));
            check("lock_g1", W'(glog[1]), W'(4'b0010));
            check("lock_g2", W'(glog[2]), W'(4'b0010));
            check("lock_g3", W'(glog[3]), W'(4'b1000));
            check("lock_g4", W'(glog[4]), W'(4'b0010));
        end else begin
            checks++;
            errors++;
            $display("FAIL lock_count: got %0d grants required 5", glog.size());
        end
`endif

        // Random traffic with random backpressure and occasional reset.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            step();
            cores_update(0);
            bus.out_ready = ($urandom % 4 != 0);
            rst = ($urandom % 300 == 0);
`ifdef SHARED_ARB_LOCK_EN
            bus.lock = 4'($urandom);
`endif
        end
        rst           = 1'b0;
        bus.req       = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) step();
        check("drain_queue", W'(exp_q.size()), W'(0));

        // LAT=1 instance: valid one edge after capture, then clean idle.
        rst1 = 1'b0;
        bus1.req_data[W-1:0] = 64'h0123_4567_89AB_CDEF;
        bus1.req       = 4'b0001;
        bus1.out_ready = 1'b1;
        step();
        check("lat1_gnt", W'(bus1.gnt), W'(4'b0001));
        check("lat1_busy", W'(bus1.busy), W'(1));
        check("lat1_valid_early", W'(bus1.out_valid), W'(0));
        bus1.req = 4'b0000;
        step();
        check("lat1_valid", W'(bus1.out_valid), W'(1));
        check("lat1_id", W'(bus1.out_id), W'(0));
        check("lat1_data", bus1.out_data, 64'h0123_4567_89AB_CDEF);
        check("lat1_gnt_clear", W'(bus1.gnt), W'(0));
        for (int k = 0; k < 4; k++) begin
            step();
            check("lat1_idle_valid", W'(bus1.out_valid), W'(0));
            check("lat1_idle_busy", W'(bus1.busy), W'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
